// File: rtl/matriz_teclado.sv
`default_nettype none
// ============================================================================
// Module   : matriz_teclado
// Purpose  : Keypad matrix scanner. Drives one column at a time (one-hot,
//            active-high), samples the row-sense lines, debounces presses and
//            releases, and reports the accepted key as a code plus a
//            one-cycle valid pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock         in   1     system clock
//   reset         in   1     synchronous, active-high reset
//   linhas        in   ROWS  row sense, active-high, asynchronous to clock
//   colunas       out  COLS  one-hot column drive, active-high
//   tecla         out  KW    last accepted key code = col*ROWS + row
//   tecla_valida  out  1     one-cycle pulse when tecla is (re)reported
//   pressionada   out  1     high while the accepted key is held
// Build option
//   MATRIZ_TECLADO_REPEAT_EN : when defined, a held key re-pulses
//                              tecla_valida every REPEAT_TICKS high samples.
// ============================================================================
module matriz_teclado #(
  parameter int COLS         = 4,
  parameter int ROWS         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_N   = 4,
  parameter int REPEAT_TICKS = 250,
  parameter int KW           = $clog2(COLS * ROWS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ROWS-1:0] linhas,
  output logic [COLS-1:0] colunas,
  output logic [KW-1:0]   tecla,
  output logic            tecla_valida,
  output logic            pressionada
);

  localparam int c_dwell_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_col_w   = $clog2(COLS);
  localparam int c_row_w   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_cnt_w   = $clog2(DEBOUNCE_N + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t               r_state;
  logic [ROWS-1:0]      r_sync1;
  logic [ROWS-1:0]      r_rs;
  logic [c_dwell_w-1:0] r_dwell;
  logic [c_col_w-1:0]   r_col;
  logic [c_row_w-1:0]   r_row;
  logic [c_cnt_w-1:0]   r_cnt;

  logic                 w_tick;
  logic                 w_any;
  logic                 w_cand_high;
  logic [c_row_w-1:0]   w_low_row;
  logic [c_cnt_w-1:0]   w_cnt_next;
  logic                 w_cnt_done;
  logic [c_col_w-1:0]   w_col_next;
  logic [COLS-1:0]      w_colunas_next;
  logic [KW-1:0]        w_code;

  assign w_tick      = (r_dwell == c_dwell_w'(SCAN_DIV - 1));
  assign w_any       = |r_rs;
  // The column is frozen outside SCAN, so the candidate row of the current
  // column is exactly the latched key.
  assign w_cand_high = r_rs[r_row];
  assign w_cnt_next  = r_cnt + c_cnt_w'(1);
  assign w_cnt_done  = (w_cnt_next == c_cnt_w'(DEBOUNCE_N));
  assign w_col_next  = (r_col == c_col_w'(COLS - 1)) ? '0 : r_col + c_col_w'(1);
  assign w_colunas_next = {colunas[COLS-2:0], colunas[COLS-1]};
  assign w_code      = KW'(r_col) * KW'(ROWS) + KW'(r_row);

  // Lowest set row wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (r_rs[r]) w_low_row = c_row_w'(r);
    end
  end

`ifdef MATRIZ_TECLADO_REPEAT_EN
  localparam int c_rep_w = $clog2(REPEAT_TICKS + 1);
  logic [c_rep_w-1:0] r_rep;
  logic [c_rep_w-1:0] w_rep_next;
  assign w_rep_next = r_rep + c_rep_w'(1);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_SCAN;
      r_sync1      <= '0;
      r_rs         <= '0;
      r_dwell      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_cnt        <= '0;
      colunas      <= COLS'(1);
      tecla        <= '0;
      tecla_valida <= 1'b0;
      pressionada  <= 1'b0;
`ifdef MATRIZ_TECLADO_REPEAT_EN
      r_rep        <= '0;
`endif
    end else begin
      r_sync1      <= linhas;
      r_rs         <= r_sync1;
      r_dwell      <= w_tick ? '0 : r_dwell + c_dwell_w'(1);
      tecla_valida <= 1'b0;

      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_any) begin
              r_row   <= w_low_row;
              r_cnt   <= '0;
              r_state <= ST_DEBOUNCE;
            end else begin
              r_col   <= w_col_next;
              colunas <= w_colunas_next;
            end
          end

          ST_DEBOUNCE: begin
            if (w_cand_high) begin
              if (w_cnt_done) begin
                tecla        <= w_code;
                tecla_valida <= 1'b1;
                pressionada  <= 1'b1;
                r_cnt        <= '0;
                r_state      <= ST_HELD;
`ifdef MATRIZ_TECLADO_REPEAT_EN
                r_rep        <= '0;
`endif
              end else begin
                r_cnt <= w_cnt_next;
              end
            end else begin
              // Bounce: abandon the candidate and move on.
              r_state <= ST_SCAN;
              r_col   <= w_col_next;
              colunas <= w_colunas_next;
            end
          end

          ST_HELD: begin
            if (w_cand_high) begin
              r_cnt <= '0;
`ifdef MATRIZ_TECLADO_REPEAT_EN
              if (w_rep_next == c_rep_w'(REPEAT_TICKS)) begin
                tecla_valida <= 1'b1;
                r_rep        <= '0;
              end else begin
                r_rep <= w_rep_next;
              end
`endif
            end else begin
`ifdef MATRIZ_TECLADO_REPEAT_EN
              r_rep <= '0;
`endif
              if (w_cnt_done) begin
                pressionada <= 1'b0;
                r_cnt       <= '0;
                r_state     <= ST_SCAN;
                r_col       <= w_col_next;
                colunas     <= w_colunas_next;
              end else begin
                r_cnt <= w_cnt_next;
              end
            end
          end

          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matriz_teclado.sv
`default_nettype none
// ============================================================================
// Module   : tb_matriz_teclado
// Purpose  : Self-checking bench for matriz_teclado. Expected key codes are
//            queued when a press is staged; a monitor pops and compares on
//            every tecla_valida pulse. Directed checks cover scan timing,
//            hold/release, bounce, multiple keys and mid-debounce reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matriz_teclado;

  localparam int COLS         = 4;
  localparam int ROWS         = 4;
  localparam int SCAN_DIV     = 8;
  localparam int DEBOUNCE_N   = 4;
  localparam int REPEAT_TICKS = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] linhas;
  logic [3:0] colunas;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       pressionada;

  logic [15:0] pk;              // pressed(c,r) at bit c*ROWS + r
  logic [3:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;       // edges since reset release; equals dwell count mod SCAN_DIV

  always #5 clock = ~clock;

  matriz_teclado #(
    .COLS        (COLS),
    .ROWS        (ROWS),
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_N  (DEBOUNCE_N),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .linhas      (linhas),
    .colunas     (colunas),
    .tecla       (tecla),
    .tecla_valida(tecla_valida),
    .pressionada (pressionada)
  );

  // Key matrix: a row reads high when its driven column has that key down.
  always_comb begin
    linhas = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (colunas[c] && pk[c*ROWS + r]) linhas[r] = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    logic       prev_v;
    logic [3:0] e;
    prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (tecla_valida) begin
          n_vec = n_vec + 1;
          if (prev_v) begin
            n_err = n_err + 1;
            $display("FAIL valid_width: tecla_valida high 2 cycles in a row, required 1");
          end else if (exp_q.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL unexpected_pulse: tecla=%0d pulsed, required no pulse", tecla);
          end else begin
            e = exp_q.pop_front();
            if (tecla !== e) begin
              n_err = n_err + 1;
              $display("FAIL tecla_code: got %0d, required %0d", tecla, e);
            end
          end
        end
        prev_v = tecla_valida;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec = n_vec + 1;
    if (act !== req) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] want);
    for (int i = 0; i < 80; i++) begin
      @(posedge clock);
      #1;
      if (colunas == want) break;
    end
    check("wait_colunas", 32'(colunas), 32'(want));
  endtask

  task automatic wait_press(input logic lvl, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clock);
      #1;
      if (pressionada == lvl) break;
    end
    check("wait_pressionada", 32'(pressionada), 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pk    = '0;
    step(3);
    reset = 1'b0;

    // Reset state and free-running scan.
    check("rst_colunas",      32'(colunas),      32'h1);
    check("rst_tecla",        32'(tecla),        32'h0);
    check("rst_valida",       32'(tecla_valida), 32'h0);
    check("rst_pressionada",  32'(pressionada),  32'h0);
    step(7);  check("scan_col0_hold", 32'(colunas), 32'h1);
    step(1);  check("scan_col1",      32'(colunas), 32'h2);
    step(8);  check("scan_col2",      32'(colunas), 32'h4);
    step(8);  check("scan_col3",      32'(colunas), 32'h8);
    step(8);  check("scan_wrap",      32'(colunas), 32'h1);

    // Hold (col2,row1) = 9.
    pk[2*ROWS + 1] = 1'b1;
    exp_q.push_back(4'd9);
`ifdef MATRIZ_TECLADO_REPEAT_EN
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd9);
`endif
    wait_press(1'b1, 300);
    check("hold_tecla",   32'(tecla),   32'd9);
    check("hold_colunas", 32'(colunas), 32'h4);
    step(40);
    check("hold_frozen",  32'(colunas),     32'h4);
    check("hold_press",   32'(pressionada), 32'h1);
    do begin
      @(posedge clock);
      #1;
    end while (cyc % SCAN_DIV != 0);
    pk = '0;
    step(31); check("release_early", 32'(pressionada), 32'h1);
    step(1);  check("release_press", 32'(pressionada), 32'h0);
    check("release_resume", 32'(colunas), 32'h8);
    check("hold_pending", 32'(exp_q.size()), 32'd0);

    // Bounce on (col3,row2): too few stable ticks.
    wait_col(4'h4);
    wait_col(4'h8);
    pk[3*ROWS + 2] = 1'b1;
    step(16); check("bounce_frozen", 32'(colunas), 32'h8);
    step(8);
    pk = '0;
    step(8);
    check("bounce_colunas", 32'(colunas),     32'h1);
    check("bounce_tecla",   32'(tecla),       32'd9);
    check("bounce_press",   32'(pressionada), 32'h0);

    // Two keys in col1: row0 wins; row3 found only after full release.
    pk[1*ROWS + 3] = 1'b1;
    pk[1*ROWS + 0] = 1'b1;
    exp_q.push_back(4'd4);
    wait_press(1'b1, 300);
    check("multi_tecla", 32'(tecla), 32'd4);
    pk[1*ROWS + 0] = 1'b0;
    step(16); check("multi_still_held", 32'(pressionada), 32'h1);
    wait_press(1'b0, 100);
    check("multi_pending", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(4'd7);
    wait_press(1'b1, 300);
    check("multi_second", 32'(tecla), 32'd7);
    pk = '0;
    wait_press(1'b0, 100);

    // Reset two ticks into DEBOUNCE on (col2,row3).
    wait_col(4'h2);
    wait_col(4'h4);
    pk[2*ROWS + 3] = 1'b1;
    step(24); check("rstmid_frozen", 32'(colunas), 32'h4);
    reset = 1'b1;
    step(1);
    check("rstmid_colunas", 32'(colunas),      32'h1);
    check("rstmid_press",   32'(pressionada),  32'h0);
    check("rstmid_valida",  32'(tecla_valida), 32'h0);
    check("rstmid_tecla",   32'(tecla),        32'h0);
    pk = '0;
    step(1);
    reset = 1'b0;
    step(80);

`ifdef MATRIZ_TECLADO_REPEAT_EN
    // Auto-repeat: (col0,row0) held 10 ticks after acceptance.
    for (int i = 0; i < 4; i++) exp_q.push_back(4'd0);
    pk[0] = 1'b1;
    wait_press(1'b1, 300);
    step(80);
    pk = '0;
    wait_press(1'b0, 100);
    check("repeat_pending", 32'(exp_q.size()), 32'd0);
`endif

    step(4);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
